// File: rtl/seven_seg_scan_ctrl.sv
// Time-division scan controller for a multiplexed 7-segment display.
// A single shared hex decoder is fed one nibble per slot. Each slot starts with
// a dead time, so the decoder's one-cycle latency settles before a digit is
// enabled. A pending/committed double buffer keeps every frame tear-free.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  S_BLANK | dead time: all digits off, nibble of the current index presented
//  S_SHOW  | digit enable of the current index asserted (unless masked)

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 25000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [4*NUM_DIGITS-1:0] i_Data,
  input  logic                    i_Data_DV,
  input  logic [NUM_DIGITS-1:0]   i_Blank_Mask,
  output logic                    o_Pending,
  output logic [3:0]              o_Nibble,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Frame_Start
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);

  typedef enum logic {S_BLANK = 1'b0, S_SHOW = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [4*NUM_DIGITS-1:0] committed_q;
  logic                    pend_q, pend_d;
  logic [3:0]              nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_start_q, frame_start_d;
  logic                    commit;

  // The position registers describe the clock whose outputs are registered at
  // the next edge, so reset parks them on the first clock of a frame.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q <= S_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slot sequencing: BLANK_CYCLES of dead time, then SCAN_DIV of display.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end
      end
      S_SHOW: begin
        if (cnt_q == CW'(SCAN_DIV - 1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Commit happens at the end of the frame-start clock; the nibble of slot 0
  // is taken from the buffer that is about to be committed so that the whole
  // slot shows the new frame.
  assign commit = frame_start_q & pend_q;

  // Next values for the registered outputs and the pending buffer.
  always_comb begin
    pend_data_d   = i_Data_DV ? i_Data : pend_data_q;
    pend_d        = i_Data_DV | (pend_q & ~commit);
    frame_start_d = (state_q == S_BLANK) && (idx_q == '0) && (cnt_q == '0);
    digit_en_d    = '0;
    if (state_q == S_SHOW && !i_Blank_Mask[idx_q])
      digit_en_d = NUM_DIGITS'(1) << idx_q;
    nibble_d = nibble_q;
    if (state_q == S_BLANK && cnt_q == '0) begin
      if (frame_start_d && pend_d)
        nibble_d = pend_data_d[{idx_q, 2'b00} +: 4];
      else
        nibble_d = committed_q[{idx_q, 2'b00} +: 4];
    end
  end

  // Output and buffer registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      pend_data_q   <= '0;
      committed_q   <= '0;
      pend_q        <= 1'b0;
      nibble_q      <= '0;
      digit_en_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pend_data_q   <= pend_data_d;
      pend_q        <= pend_d;
      nibble_q      <= nibble_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
      if (commit)
        committed_q <= pend_data_q;
    end
  end

  assign o_Pending     = pend_q;
  assign o_Nibble      = nibble_q;
  assign o_Digit_En    = digit_en_q;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4,
// BLANK_CYCLES=2 (slot = 6 clocks, frame = 24 clocks).

module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [15:0] data = '0;
  logic        dv = 1'b0;
  logic [3:0]  mask = '0;
  logic        pending;
  logic [3:0]  nibble;
  logic [3:0]  digit_en;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;
  int c = -1;
  logic [3:0] prev_nib = '0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .BLANK_CYCLES(2)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Data       (data),
    .i_Data_DV    (dv),
    .i_Blank_Mask (mask),
    .o_Pending    (pending),
    .o_Nibble     (nibble),
    .o_Digit_En   (digit_en),
    .o_Frame_Start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at clk %0d: got %h expected %h", tag, c, obs, exp);
    end
  endtask

  task automatic adv_to(input int p);
    for (int i = 0; i < 24 && (c % 24) != p; i++) tick();
  endtask

  // Runs one full frame from pos 0 to pos 23, checking every clock.
  task automatic run_frame(input logic [15:0] d, input logic [3:0] m,
                           input logic p0, input logic p1,
                           input logic dv0, input logic [15:0] d0);
    int slot, off;
    logic [3:0] exp_en;
    for (int k = 0; k < 24; k++) begin
      tick();
      slot = k / 6;
      off  = k % 6;
      exp_en = (off >= 2 && !m[slot]) ? (4'b0001 << slot) : 4'b0000;
      chk("frame_start", {15'd0, frame_start}, {15'd0, k == 0});
      chk("digit_en", {12'd0, digit_en}, {12'd0, exp_en});
      chk("nibble", {12'd0, nibble}, {12'd0, d[slot*4 +: 4]});
      chk("pending", {15'd0, pending}, {15'd0, (k == 0) ? p0 : p1});
      chk("ghost", {15'd0, (digit_en != 0) && (nibble != prev_nib)}, 16'd0);
      chk("onehot", {15'd0, $countones(digit_en) > 1}, 16'd0);
      prev_nib = nibble;
      if (k == 0 && dv0) begin
        data = d0;
        dv   = 1'b1;
      end else if (k == 1) begin
        dv = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset held for 3 clocks
    rst_l = 1'b0;
    repeat (3) tick();
    chk("rst_en", {12'd0, digit_en}, 16'd0);
    chk("rst_fs", {15'd0, frame_start}, 16'd0);
    chk("rst_nib", {12'd0, nibble}, 16'd0);
    chk("rst_pend", {15'd0, pending}, 16'd0);

    // Scenario 1: scan pattern after release, two frames
    rst_l = 1'b1;
    c = -1;
    run_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
    run_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);

    // Scenario 2: mid-frame strobe, committed at next frame start
    adv_to(10);
    data = 16'h1234;
    dv = 1'b1;
    tick();
    dv = 1'b0;
    chk("s2_pend_set", {15'd0, pending}, 16'd1);
    chk("s2_old_nib", {12'd0, nibble}, 16'd0);
    adv_to(23);
    chk("s2_pend_hold", {15'd0, pending}, 16'd1);
    run_frame(16'h1234, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0);

    // Scenario 3: latest strobe wins
    adv_to(5);
    data = 16'hAAAA;
    dv = 1'b1;
    tick();
    dv = 1'b0;
    adv_to(12);
    data = 16'hBBBB;
    dv = 1'b1;
    tick();
    dv = 1'b0;
    adv_to(23);
    run_frame(16'hBBBB, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0);

    // Scenario 4: strobe coincident with frame start while 5555 pending
    adv_to(15);
    data = 16'h5555;
    dv = 1'b1;
    tick();
    dv = 1'b0;
    adv_to(23);
    run_frame(16'h5555, 4'b0000, 1'b1, 1'b1, 1'b1, 16'hCCCC);
    run_frame(16'hCCCC, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0);

    // Scenario 5: blank mask, frame length unchanged
    mask = 4'b1010;
    run_frame(16'hCCCC, 4'b1010, 1'b0, 1'b0, 1'b0, 16'h0);
    mask = 4'b0000;
    run_frame(16'hCCCC, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);

    // Scenario 6: reset during S_SHOW of index 2
    adv_to(12);
    data = 16'h9999;
    dv = 1'b1;
    tick();
    dv = 1'b0;
    adv_to(14);
    chk("s6_show2", {12'd0, digit_en}, 16'h0004);
    rst_l = 1'b0;
    tick();
    chk("s6_rst_en", {12'd0, digit_en}, 16'd0);
    chk("s6_rst_pend", {15'd0, pending}, 16'd0);
    chk("s6_rst_nib", {12'd0, nibble}, 16'd0);
    tick();
    rst_l = 1'b1;
    c = -1;
    prev_nib = '0;
    run_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
    run_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
